// File: rtl/mult_serial_host.sv
// mult_serial_host
//   Host side of a bit-serial multiplier link. Accepts a 16x16 operand pair,
//   pulses dev_rst_o to resynchronise the target, shifts both operands out
//   LSB first, waits TURN_CYC idle cycles, then captures the 32-bit product
//   two bits per cycle (low half on out_1_i, high half on out_2_i) and holds
//   it under a valid/ready handshake.
//
// Ports
//   wb_clk_i, wb_rst_i    clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake; in_a multiplicand, in_b multiplier
//   dev_rst_o             one-cycle target counter resync pulse
//   a_pad_o, b_pad_o      serial operand bits, LSB first
//   out_1_i, out_2_i      serial product bits (low half, high half)
//   res_valid/res_ready   result handshake; res_p reassembled product
//   busy                  high whenever not IDLE
module mult_serial_host #(
  parameter int OP_W     = 16,
  parameter int TURN_CYC = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              dev_rst_o,
  output logic              a_pad_o,
  output logic              b_pad_o,
  input  logic              out_1_i,
  input  logic              out_2_i,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*OP_W-1:0] res_p,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    DRST,
    LOAD,
    TURN,
    CAPT,
    DONE
  } state_e;

  localparam logic [4:0] BIT_LAST  = 5'(OP_W - 1);
  localparam logic [4:0] TURN_LAST = (TURN_CYC > 0) ? 5'(TURN_CYC - 1) : 5'd0;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [OP_W-1:0]     a_q, b_q;
  logic [2*OP_W-1:0]   p_q;
  logic                accept;

  assign accept = in_valid && (state_q == IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRST;
          cnt_d   = '0;
        end
      end
      DRST: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = (TURN_CYC == 0) ? CAPT : TURN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      CAPT: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DONE: begin
        // Handshake only returns to IDLE; new operands wait for that cycle.
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Operand shadow and product assembly; {1'b1, k} addresses bit OP_W+k.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else if (accept) begin
      a_q <= in_a;
      b_q <= in_b;
      p_q <= '0;
    end else if (state_q == CAPT) begin
      p_q[{1'b0, cnt_q[3:0]}] <= out_1_i;
      p_q[{1'b1, cnt_q[3:0]}] <= out_2_i;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    dev_rst_o = (state_q == DRST);
    a_pad_o   = (state_q == LOAD) && a_q[cnt_q[3:0]];
    b_pad_o   = (state_q == LOAD) && b_q[cnt_q[3:0]];
    res_valid = (state_q == DONE);
    res_p     = p_q;
  end

endmodule

// File: tb/tb_mult_serial_host.sv
module tb_mult_serial_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [15:0] in_a [2];
  logic [15:0] in_b [2];
  logic        dev_rst [2];
  logic        a_pad [2];
  logic        b_pad [2];
  logic        out1 [2];
  logic        out2 [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic [31:0] res_p [2];
  logic        busy [2];

  int nvec = 0;
  int nerr = 0;

  // Instance 0: default turnaround; instance 1: TURN_CYC = 0.
  mult_serial_host #(.OP_W(16), .TURN_CYC(1)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]),
    .dev_rst_o(dev_rst[0]), .a_pad_o(a_pad[0]), .b_pad_o(b_pad[0]),
    .out_1_i(out1[0]), .out_2_i(out2[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_p(res_p[0]), .busy(busy[0])
  );

  mult_serial_host #(.OP_W(16), .TURN_CYC(0)) u_dut_t0 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]),
    .dev_rst_o(dev_rst[1]), .a_pad_o(a_pad[1]), .b_pad_o(b_pad[1]),
    .out_1_i(out1[1]), .out_2_i(out2[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_p(res_p[1]), .busy(busy[1])
  );

  // Target multiplier model: resyncs on dev_rst, shifts in 16 operand bits,
  // multiplies, then serialises the product after its turnaround gap.
  int          pos [2] = '{1000, 1000};
  logic [15:0] ta [2];
  logic [15:0] tbv [2];
  logic [31:0] prod [2];

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int k;
      if (dev_rst[u]) begin
        pos[u] = 0;
      end else if (pos[u] < 1000) begin
        if (pos[u] < 16) begin
          ta[u][pos[u]]  = a_pad[u];
          tbv[u][pos[u]] = b_pad[u];
        end
        pos[u]++;
      end
      prod[u] = 32'(ta[u]) * 32'(tbv[u]);
      k = pos[u] - 17 - ((u == 0) ? 1 : 0);
      if (k >= 0 && k < 16) begin
        out1[u] = prod[u][k];
        out2[u] = prod[u][16+k];
      end else begin
        out1[u] = 1'b0;
        out2[u] = 1'b0;
      end
    end
  end

  logic [31:0] sbq0[$];
  logic [31:0] sbq1[$];

  task automatic sb_push(input int u, input logic [31:0] v);
    if (u == 0) sbq0.push_back(v);
    else        sbq1.push_back(v);
  endtask

  task automatic sb_pop(input int u, output logic [31:0] v);
    v = 32'hxxxxxxxx;
    if (u == 0 && sbq0.size() > 0) v = sbq0.pop_front();
    if (u == 1 && sbq1.size() > 0) v = sbq1.pop_front();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; in_a[u] = '0; in_b[u] = '0; res_ready[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      nvec++; if (in_ready[u] !== 1'b1) begin nerr++; $display("FAIL reset_in_ready[%0d] got %b want 1", u, in_ready[u]); end
      nvec++; if (res_valid[u] !== 1'b0 || busy[u] !== 1'b0) begin nerr++; $display("FAIL reset_valid_busy[%0d] got %b%b want 00", u, res_valid[u], busy[u]); end
      nvec++; if ({dev_rst[u], a_pad[u], b_pad[u]} !== 3'b000) begin nerr++; $display("FAIL reset_pads[%0d] got %b want 000", u, {dev_rst[u], a_pad[u], b_pad[u]}); end
      nvec++; if (res_p[u] !== 32'h0) begin nerr++; $display("FAIL reset_res_p[%0d] got %h want 00000000", u, res_p[u]); end
    end
  endtask

  task automatic run_txn(input int u, input logic [15:0] a, input logic [15:0] b,
                         input int exp_lat, input int hold);
    int n, ndev;
    logic ok;
    logic [31:0] held, exp;
    @(negedge clk);
    in_valid[u] = 1'b1; in_a[u] = a; in_b[u] = b; res_ready[u] = 1'b0;
    sb_push(u, 32'(a) * 32'(b));
    @(negedge clk);
    in_valid[u] = 1'b0;
    n = 1; ndev = 0; ok = 1'b1;
    while (n < 100 && res_valid[u] !== 1'b1) begin
      if (dev_rst[u] === 1'b1) ndev++;
      if (in_ready[u] !== 1'b0 || busy[u] !== 1'b1) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    nvec++; if (n != exp_lat) begin nerr++; $display("FAIL latency[%0d] got %0d want %0d", u, n, exp_lat); end
    nvec++; if (ndev != 1) begin nerr++; $display("FAIL dev_rst_pulses[%0d] got %0d want 1", u, ndev); end
    nvec++; if (!ok) begin nerr++; $display("FAIL busy_not_ready[%0d] got 0 want 1", u); end
    held = res_p[u];
    if (hold > 0) begin
      ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
        in_valid[u] = 1'b1;
        @(negedge clk);
        if (res_valid[u] !== 1'b1 || res_p[u] !== held || in_ready[u] !== 1'b0) ok = 1'b0;
      end
      in_valid[u] = 1'b0;
      nvec++; if (!ok) begin nerr++; $display("FAIL backpressure[%0d] got unstable want held %h", u, held); end
    end
    sb_pop(u, exp);
    nvec++; if (res_p[u] !== exp) begin nerr++; $display("FAIL product[%0d] got %h want %h", u, res_p[u], exp); end
    res_ready[u] = 1'b1;
    @(negedge clk);
    res_ready[u] = 1'b0;
    nvec++; if (in_ready[u] !== 1'b1 || res_valid[u] !== 1'b0) begin nerr++; $display("FAIL idle_after_done[%0d] got %b%b want 10", u, in_ready[u], res_valid[u]); end
  endtask

  task automatic test_basic;
    run_txn(0, 16'h0003, 16'h0005, 35, 0);
    nvec++; if (ta[0] !== 16'h0003 || tbv[0] !== 16'h0005) begin nerr++; $display("FAIL pad_bits got %h/%h want 0003/0005", ta[0], tbv[0]); end
  endtask

  task automatic test_all_ones_backpressure;
    run_txn(0, 16'hFFFF, 16'hFFFF, 35, 10);
  endtask

  task automatic test_turn0;
    run_txn(1, 16'h1234, 16'h0002, 34, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 3; i++)
      run_txn(0, 16'($urandom), 16'($urandom), 35, i);
  endtask

  task automatic test_reset_mid_load;
    @(negedge clk);
    in_valid[0] = 1'b1; in_a[0] = 16'hABCD; in_b[0] = 16'h1357;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (8) @(negedge clk);
    nvec++; if ({a_pad[0], b_pad[0]} !== 2'b10) begin nerr++; $display("FAIL load_bit7 got %b want 10", {a_pad[0], b_pad[0]}); end
    rst = 1'b1;
    @(negedge clk);
    nvec++; if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || res_valid[0] !== 1'b0) begin nerr++; $display("FAIL abort_state got rdy%b busy%b vld%b want 1 0 0", in_ready[0], busy[0], res_valid[0]); end
    nvec++; if ({dev_rst[0], a_pad[0], b_pad[0]} !== 3'b000 || res_p[0] !== 32'h0) begin nerr++; $display("FAIL abort_outputs got %b %h want 000 00000000", {dev_rst[0], a_pad[0], b_pad[0]}, res_p[0]); end
    rst = 1'b0;
    run_txn(0, 16'h0002, 16'h0002, 35, 0);
  endtask

  task automatic test_back_to_back;
    int n, got, acc, r1, r2;
    logic [31:0] exp;
    @(negedge clk);
    in_valid[0] = 1'b1; in_a[0] = 16'h00FF; in_b[0] = 16'h0101; res_ready[0] = 1'b1;
    n = 0; got = 0; acc = 0; r1 = -1; r2 = -1;
    while (got < 2 && n < 300) begin
      if (in_valid[0] && in_ready[0] === 1'b1) begin
        sb_push(0, 32'(in_a[0]) * 32'(in_b[0]));
        acc++;
      end
      if (r1 >= 0 && n == r1 + 1) begin
        nvec++; if (in_ready[0] !== 1'b1 || res_valid[0] !== 1'b0) begin nerr++; $display("FAIL b2b_idle_gap got %b%b want 10", in_ready[0], res_valid[0]); end
      end
      if (res_valid[0] === 1'b1) begin
        sb_pop(0, exp);
        nvec++; if (res_p[0] !== exp) begin nerr++; $display("FAIL b2b_result%0d got %h want %h", got, res_p[0], exp); end
        got++;
        if (got == 1) r1 = n; else r2 = n;
      end
      @(negedge clk);
      n++;
      if (acc == 1) begin in_a[0] = 16'hBEEF; in_b[0] = 16'h1234; end
      if (acc >= 2) in_valid[0] = 1'b0;
    end
    in_valid[0] = 1'b0; res_ready[0] = 1'b0;
    nvec++; if (got != 2 || r2 - r1 != 36) begin nerr++; $display("FAIL b2b_spacing got %0d results gap %0d want 2 results gap 36", got, r2 - r1); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_all_ones_backpressure;
    test_turn0;
    test_reset_mid_load;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish want finish within 500000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_serial_host.md
MULT_SERIAL_HOST -- requirements
Module: mult_serial_host

Interface
REQ-001 Parameter OP_W, default 16: operand width in bits, fixed at 16.
REQ-002 Parameter TURN_CYC, default 1, legal range 0..15: idle cycles between the last operand bit and the first product bit.
REQ-003 The block SHALL have exactly one clock and a synchronous active-high reset.
REQ-004 wb_clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-005 wb_rst_i  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand pair on in_a/in_b is valid.
REQ-007 in_ready  output  1  block accepts an operand pair this cycle.
REQ-008 in_a  input  16  multiplicand.
REQ-009 in_b  input  16  multiplier.
REQ-010 dev_rst_o  output  1  one-cycle pulse that resynchronises the target multiplier's bit counters.
REQ-011 a_pad_o  output  1  serial multiplicand bit, LSB first.
REQ-012 b_pad_o  output  1  serial multiplier bit, LSB first.
REQ-013 out_1_i  input  1  serial product low-half bit from the target.
REQ-014 out_2_i  input  1  serial product high-half bit from the target.
REQ-015 res_valid  output  1  res_p holds a complete product.
REQ-016 res_ready  input  1  consumer accepts res_p.
REQ-017 res_p  output  32  reassembled product.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, DRST, LOAD, TURN, CAPT and DONE; it holds a 5-bit bit counter cnt.
REQ-020 IDLE: in_ready=1; in_valid&in_ready latches in_a/in_b into shadow registers, clears the product register, and moves to DRST.
REQ-021 DRST: exactly one cycle with dev_rst_o=1, then LOAD with cnt=0.
REQ-022 LOAD: 16 cycles; in the cycle with cnt=k (0..15), a_pad_o=a[k] and b_pad_o=b[k]; at cnt=15, go to TURN (or to CAPT if TURN_CYC=0); cnt resets to 0.
REQ-023 TURN: TURN_CYC cycles, pads driven 0, then CAPT with cnt=0.
REQ-024 CAPT: 16 cycles; at the rising edge ending the cycle with cnt=k, p[k]<=out_1_i and p[16+k]<=out_2_i; after k=15, go to DONE.
REQ-025 DONE: res_valid=1, res_p stable; on res_valid&res_ready, go to IDLE.
REQ-026 Latency from the accept edge to res_valid SHALL be 1+16+TURN_CYC+16+1 cycles; with the default, res_valid is first high in cycle 35 after the accept (accept edge = cycle 0).
REQ-027 in_ready SHALL be 0 in every state except IDLE; an operand offered outside IDLE is not consumed.
REQ-028 A DONE-state handshake SHALL NOT accept new operands in the same cycle; the earliest next accept is the following IDLE cycle.
REQ-029 Backpressure: res_valid SHALL stay high and res_p unchanged for as long as res_ready is 0.
REQ-030 a_pad_o, b_pad_o and dev_rst_o SHALL be 0 in all states other than those specified above.
REQ-031 The counter SHALL NOT wrap past 15 in any state; the phase transition occurs on cnt=15 (or on cnt=TURN_CYC-1 in TURN).
REQ-032 Product bits SHALL be interpreted only as captured; the block performs no arithmetic correction.

Reset
REQ-033 While wb_rst_i=1 at a clock edge, the state goes to IDLE and cnt, shadow operands and res_p clear to 0.
REQ-034 Output values under reset: in_ready=1 from the first cycle after reset, and res_valid, busy, dev_rst_o, a_pad_o and b_pad_o are all 0.
REQ-035 Reset asserted in any state, including mid-LOAD or mid-CAPT, SHALL abort the transaction with no result produced.
REQ-036 The next transaction SHALL start with a fresh DRST pulse.

Verification
REQ-037 a=3, b=5, target model returns 15 -> dev_rst_o pulses once; pads carry 1100.. and 1010..; res_p=0x0000000F at cycle 35.
REQ-038 a=0xFFFF, b=0xFFFF, model returns 0xFFFE0001 -> res_p=0xFFFE0001, with all 32 bits checked.
REQ-039 TURN_CYC=0 and a=0x1234, b=0x0002 -> CAPT immediately follows LOAD; res_p=0x00002468 at cycle 34.
REQ-040 res_ready held 0 for 10 cycles in DONE -> res_valid stays 1, res_p stable, in_ready stays 0; release -> IDLE the next cycle.
REQ-041 wb_rst_i pulsed at LOAD cnt=7 -> the next cycle is IDLE with all outputs at reset values; a new transaction a=2, b=2 completes with res_p=0x00000004.
REQ-042 Back-to-back: in_valid held high with res_ready=1 across two operand pairs -> two results in order, each separated by one IDLE cycle.
